// File: rtl/pe_feeder.sv
// Feeds a target character stream into PE0 of a systolic array, then flushes for N_PE cycles.
// Optional: define PE_FEEDER_CNT_EN to add the 16-bit char_cnt output.
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

module pe_feeder #(
  parameter int N_PE = 64,
  parameter int W    = `V_E_F_Bit
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_t,
  input  logic         in_last,
  input  logic [W-1:0] minusAlpha,
  output logic         enable,
  output logic         newLineOut,
  output logic [1:0]   tOut,
  output logic [W-1:0] vOut,
  output logic [W-1:0] vOut_alpha,
  output logic [W-1:0] fOut,
  output logic         busy,
  output logic         done,
  output logic         err
`ifdef PE_FEEDER_CNT_EN
  ,
  output logic [15:0]  char_cnt
`endif
);

  localparam int CW = $clog2(N_PE + 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(N_PE - 1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  state_t         state_q, state_d;
  logic           first_q, first_d;
  logic [CW-1:0]  flush_cnt_q, flush_cnt_d;
  logic           enable_q, enable_d;
  logic           newline_q, newline_d;
  logic [1:0]     t_q, t_d;
  logic [W-1:0]   valpha_q, valpha_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           in_ready_q, in_ready_d;
`ifdef PE_FEEDER_CNT_EN
  logic [15:0]    cnt_q, cnt_d;
`endif

  // PE outputs are registered from the decision made this cycle, so they trail the state by one edge.
  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    flush_cnt_d = flush_cnt_q;
    err_d       = err_q;
    enable_d    = 1'b0;
    newline_d   = 1'b0;
    t_d         = 2'd0;
    valpha_d    = '0;
    done_d      = 1'b0;
`ifdef PE_FEEDER_CNT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FEED;
          first_d = 1'b1;
          err_d   = 1'b0;
`ifdef PE_FEEDER_CNT_EN
          cnt_d   = 16'd0;
`endif
        end
      end
      FEED: begin
        if (in_valid) begin
          enable_d  = 1'b1;
          t_d       = in_t;
          valpha_d  = minusAlpha;
          newline_d = first_q;
          first_d   = 1'b0;
`ifdef PE_FEEDER_CNT_EN
          cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`endif
          if (in_last) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end
        end else if (!first_q) begin
          // A wait before the first character is legal; any later gap is an underrun.
          err_d = 1'b1;
        end
      end
      FLUSH: begin
        enable_d = 1'b1;
        valpha_d = minusAlpha;
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = DONE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + CW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == FEED);
    busy_d     = (state_q != IDLE) || (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      first_q     <= 1'b0;
      flush_cnt_q <= '0;
      enable_q    <= 1'b0;
      newline_q   <= 1'b0;
      t_q         <= 2'd0;
      valpha_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef PE_FEEDER_CNT_EN
      cnt_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      flush_cnt_q <= flush_cnt_d;
      enable_q    <= enable_d;
      newline_q   <= newline_d;
      t_q         <= t_d;
      valpha_q    <= valpha_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
`ifdef PE_FEEDER_CNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // The feeder never injects boundary scores, so vOut and fOut are tied off.
  assign vOut       = '0;
  assign fOut       = '0;
  assign enable     = enable_q;
  assign newLineOut = newline_q;
  assign tOut       = t_q;
  assign vOut_alpha = valpha_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign in_ready   = in_ready_q;
`ifdef PE_FEEDER_CNT_EN
  assign char_cnt   = cnt_q;
`endif

endmodule

// File: tb/tb_pe_feeder.sv
// Scoreboard bench for pe_feeder: driver queues expected PE0 beats, a negedge monitor pops and compares.
module tb_pe_feeder;
  localparam int N_PE = 8;
  localparam int W    = 16;

  typedef logic [3*W+4:0] rec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [1:0]   in_t = 2'd0;
  logic [W-1:0] minus_alpha = '0;
  logic         in_ready, enable, newLineOut, busy, done, err;
  logic [1:0]   tOut;
  logic [W-1:0] vOut, vOut_alpha, fOut;
`ifdef PE_FEEDER_CNT_EN
  logic [15:0]  char_cnt;
`endif

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done_seen = 0;
  int   n_done_exp = 0;
  rec_t exp_q[$];
  logic [1:0] seq_t[$];
  bit         seq_gap[$];
  rec_t       act_rec;

  always #5 clk = ~clk;

  pe_feeder #(.N_PE(N_PE), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_t(in_t), .in_last(in_last), .minusAlpha(minus_alpha), .enable(enable),
    .newLineOut(newLineOut), .tOut(tOut), .vOut(vOut), .vOut_alpha(vOut_alpha),
    .fOut(fOut), .busy(busy), .done(done), .err(err)
`ifdef PE_FEEDER_CNT_EN
    , .char_cnt(char_cnt)
`endif
  );

  assign act_rec = {done, enable, newLineOut, tOut, vOut_alpha, vOut, fOut};

  function automatic rec_t make_rec(input logic d, input logic e, input logic nl,
                                    input logic [1:0] t, input logic [W-1:0] a);
    return {d, e, nl, t, a, {W{1'b0}}, {W{1'b0}}};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every enable or done beat must match the next expected beat; all other cycles are quiet.
  always @(negedge clk) begin
    if (rst) begin
      if (enable || done) begin
        if (done) n_done_seen++;
        if (exp_q.size() == 0) checkOutput("unexpected_out", 64'(act_rec), 64'd0);
        else checkOutput("pe_out", 64'(act_rec), 64'(exp_q.pop_front()));
      end else begin
        checkOutput("quiet_zero", 64'(act_rec), 64'd0);
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] alpha, input int lead, input int start_mid,
                               input bit start_flush, input int abort_at);
    bit err_exp = 1'b0;
    bit got_done = 1'b0;
    int n = seq_t.size();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(make_rec(1'b0, 1'b1, (i == 0), seq_t[i], alpha));
      if (i > 0 && seq_gap[i]) err_exp = 1'b1;
    end
    for (int i = 0; i < N_PE; i++) exp_q.push_back(make_rec(1'b0, 1'b1, 1'b0, 2'd0, alpha));
    exp_q.push_back(make_rec(1'b1, 1'b0, 1'b0, 2'd0, '0));

    @(posedge clk); #1;
    minus_alpha = alpha;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("err_cleared", err, 0);
    repeat (lead) begin @(posedge clk); #1; end

    for (int i = 0; i < n; i++) begin
      if (i > 0 && seq_gap[i]) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_t     = seq_t[i];
      in_last  = (i == n - 1);
      start    = (i == start_mid);
      checkOutput("in_ready_feed", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_t     = 2'd0;
    start    = 1'b0;

    for (int c = 0; c < N_PE + 10 && !got_done; c++) begin
      @(negedge clk);
      start = (start_flush && c == 2);
      if (c == abort_at) begin
        #2 rst = 1'b0;
        #1;
        checkOutput("async_reset_outs", 64'(act_rec), 64'd0);
        checkOutput("async_reset_status", {busy, err, in_ready}, 0);
`ifdef PE_FEEDER_CNT_EN
        checkOutput("char_cnt_reset", char_cnt, 0);
`endif
        exp_q.delete();
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_release", busy, 0);
        return;
      end
      if (done) begin
        got_done = 1'b1;
        n_done_exp++;
        checkOutput("err_at_done", err, err_exp);
        checkOutput("busy_at_done", busy, 1);
`ifdef PE_FEEDER_CNT_EN
        checkOutput("char_cnt", char_cnt, n);
`endif
      end
    end
    start = 1'b0;
    if (!got_done) begin
      checkOutput("done_timeout", got_done, 1);
      exp_q.delete();
    end else begin
      @(negedge clk);
      checkOutput("busy_after_done", busy, 0);
      checkOutput("err_hold", err, err_exp);
      checkOutput("queue_empty", exp_q.size(), 0);
    end
  endtask

  task automatic load4(input bit gap3);
    seq_t.delete();
    seq_gap.delete();
    for (int i = 0; i < 4; i++) begin
      seq_t.push_back(2'(i));
      seq_gap.push_back(gap3 && i == 3);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outs", 64'(act_rec), 64'd0);
    checkOutput("reset_status", {busy, err, in_ready}, 0);
`ifdef PE_FEEDER_CNT_EN
    checkOutput("reset_char_cnt", char_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b1;

    in_valid = 1'b1;
    in_t     = 2'd3;
    in_last  = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_in_ready", in_ready, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_t     = 2'd0;

    $display("[TB] basic 4-char sequence");
    load4(1'b0);
    applyStimulus(-16'sd2, 0, -1, 1'b0, -1);

    $display("[TB] single character");
    seq_t.delete(); seq_gap.delete();
    seq_t.push_back(2'd2); seq_gap.push_back(1'b0);
    applyStimulus(16'h7FF0, 0, -1, 1'b0, -1);

    $display("[TB] underrun between chars 2 and 3");
    load4(1'b1);
    applyStimulus(-16'sd5, 0, -1, 1'b0, -1);

    $display("[TB] start pulses mid-feed and mid-flush");
    load4(1'b0);
    applyStimulus(16'h8001, 1, 1, 1'b1, -1);

    $display("[TB] reset during flush, then fresh sequence");
    load4(1'b0);
    applyStimulus(-16'sd3, 0, -1, 1'b0, 5);
    load4(1'b0);
    applyStimulus(-16'sd2, 0, -1, 1'b0, -1);

    $display("[TB] randomized sequences");
    for (int s = 0; s < 20; s++) begin
      int n;
      n = $urandom_range(1, 12);
      seq_t.delete();
      seq_gap.delete();
      for (int i = 0; i < n; i++) begin
        seq_t.push_back(2'($urandom_range(0, 3)));
        seq_gap.push_back($urandom_range(0, 4) == 0);
      end
      applyStimulus(W'($urandom), $urandom_range(0, 2), -1, 1'b0, -1);
    end

    repeat (4) @(negedge clk);
    checkOutput("done_count", n_done_seen, n_done_exp);
    checkOutput("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
